// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared pc_source and halt cause encodings for the PC unit
package pc_pkg;

  localparam logic [2:0] PCS_SEQ    = 3'd0;
  localparam logic [2:0] PCS_BRANCH = 3'd1;
  localparam logic [2:0] PCS_JUMP   = 3'd2;
  localparam logic [2:0] PCS_CALL   = 3'd3;
  localparam logic [2:0] PCS_RET    = 3'd4;

  localparam logic [2:0] HC_NONE       = 3'd0;
  localparam logic [2:0] HC_MISALIGNED = 3'd1;
  localparam logic [2:0] HC_RANGE      = 3'd2;
  localparam logic [2:0] HC_OVERFLOW   = 3'd3;
  localparam logic [2:0] HC_UNDERFLOW  = 3'd4;
  localparam logic [2:0] HC_ILLEGAL    = 3'd5;

endpackage

// File: rtl/pc_unit_ras_if.sv
// rtl/pc_unit_ras_if.sv - control inputs and PC/halt status outputs of the PC unit
interface pc_unit_ras_if #(
  parameter int XLEN      = 32,
  parameter int JT_WIDTH  = 26,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic                write_enable;
  logic                pc_write_cond;
  logic                branch_ne;
  logic                zero_flag;
  logic [2:0]          pc_source;
  logic [XLEN-1:0]     alu_result;
  logic [JT_WIDTH-1:0] jump_target;
  logic                halt_clear;
  logic [XLEN-1:0]     pc;
  logic                halt;
  logic [2:0]          halt_cause;
  logic [CW-1:0]       ras_count;

  modport master (
    output write_enable, pc_write_cond, branch_ne, zero_flag, pc_source,
           alu_result, jump_target, halt_clear,
    input  pc, halt, halt_cause, ras_count
  );

  modport slave (
    input  write_enable, pc_write_cond, branch_ne, zero_flag, pc_source,
           alu_result, jump_target, halt_clear,
    output pc, halt, halt_cause, ras_count
  );
endinterface

// File: rtl/pc_unit_ras_ras_stack.sv
// rtl/pc_unit_ras_ras_stack.sv - synchronous LIFO holding return addresses
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Entry count-1 is the most recent push; loops avoid a zero-width index when DEPTH=1.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count) top = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count) mem[i] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - next-PC select, fault checker, sticky halt and return-address stack
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              JT_WIDTH  = 26,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0100_0000,
  parameter logic [XLEN-1:0] MEM_SIZE  = 32'h0100_0000,
  parameter int              RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  pc_unit_ras_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN:0] LIMIT = {1'b0, RESET_PC} + {1'b0, MEM_SIZE};

  logic [XLEN-1:0] pc_q, seq, target, ras_top;
  logic            seq_carry;
  logic            halt_q;
  logic [2:0]      cause_q, cause;
  logic            take, act, push, pop;
  logic            ras_full, ras_empty;
  logic [CW-1:0]   ras_cnt;

  assign {seq_carry, seq} = {1'b0, pc_q} + (XLEN + 1)'(4);
  assign take = bus.write_enable | (bus.pc_write_cond & (bus.zero_flag ^ bus.branch_ne));
  // A pending halt_clear swallows any take, halted or not.
  assign act  = take & ~halt_q & ~bus.halt_clear;

  always_comb begin
    target = seq;
    case (bus.pc_source)
      PCS_BRANCH:         target = bus.alu_result;
      PCS_JUMP, PCS_CALL: target = {seq[XLEN-1:JT_WIDTH+2], bus.jump_target, 2'b00};
      PCS_RET:            target = ras_top;
      default:            target = seq;
    endcase
  end

  always_comb begin
    cause = HC_NONE;
    if (bus.pc_source > PCS_RET) begin
      cause = HC_ILLEGAL;
    end else if (bus.pc_source == PCS_RET && ras_empty) begin
      cause = HC_UNDERFLOW;
    end else if (bus.pc_source == PCS_CALL && ras_full) begin
      cause = HC_OVERFLOW;
    end else if (target[1:0] != 2'b00) begin
      cause = HC_MISALIGNED;
    end else if (target < RESET_PC || {1'b0, target} >= LIMIT ||
                 (bus.pc_source == PCS_SEQ && seq_carry)) begin
      cause = HC_RANGE;
    end
  end

  assign push = act && (cause == HC_NONE) && (bus.pc_source == PCS_CALL);
  assign pop  = act && (cause == HC_NONE) && (bus.pc_source == PCS_RET);

  ras_stack #(.WIDTH(XLEN), .DEPTH(RAS_DEPTH), .CW(CW)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (seq),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty),
    .count (ras_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      halt_q  <= 1'b0;
      cause_q <= HC_NONE;
    end else if (halt_q) begin
      if (bus.halt_clear) begin
        halt_q  <= 1'b0;
        cause_q <= HC_NONE;
      end
    end else if (act) begin
      if (cause != HC_NONE) begin
        halt_q  <= 1'b1;
        cause_q <= cause;
      end else begin
        pc_q <= target;
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.halt       = halt_q;
  assign bus.halt_cause = cause_q;
  assign bus.ras_count  = ras_cnt;
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed and randomized checks of pc_unit_ras against a queue-based model
module tb_pc_unit_ras;
  localparam int          XLEN  = 32;
  localparam int          JT    = 26;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0100_0000;
  localparam logic [31:0] MSIZE = 32'h0100_0000;
  localparam longint      TWO32 = 64'h1_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  longint m_pc = RPC;
  bit     m_halt = 1'b0;
  int     m_cause = 0;
  longint ras[$];

  pc_unit_ras_if #(.XLEN(XLEN), .JT_WIDTH(JT), .RAS_DEPTH(DEPTH)) bus ();

  pc_unit_ras #(
    .XLEN(XLEN), .JT_WIDTH(JT), .RESET_PC(RPC), .MEM_SIZE(MSIZE), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void model_step(bit r, bit we, bit cond, bit bne, bit zf, int src,
                                     longint alu, longint jt, bit hc);
    longint seq, tgt;
    int c;
    if (r) begin
      m_pc = RPC; m_halt = 0; m_cause = 0; ras.delete();
      return;
    end
    if (m_halt) begin
      if (hc) begin m_halt = 0; m_cause = 0; end
      return;
    end
    if (!(we || (cond && (zf != bne))) || hc) return;
    seq = (m_pc + 4) % TWO32;
    tgt = seq;
    if (src == 1) tgt = alu;
    if (src == 2 || src == 3) tgt = (seq / (64'd1 << 28)) * (64'd1 << 28) + jt * 4;
    if (src == 4 && ras.size() > 0) tgt = ras[$];
    c = 0;
    if (src > 4) c = 5;
    else if (src == 4 && ras.size() == 0) c = 4;
    else if (src == 3 && ras.size() == DEPTH) c = 3;
    else if (tgt % 4 != 0) c = 1;
    else if (tgt < RPC || tgt >= longint'(RPC) + longint'(MSIZE)) c = 2;
    if (c != 0) begin
      m_halt = 1; m_cause = c;
    end else begin
      if (src == 3) ras.push_back(seq);
      if (src == 4) void'(ras.pop_back());
      m_pc = tgt;
    end
  endfunction

  task automatic cycle(input bit r, input bit we, input bit cond, input bit bne, input bit zf,
                       input logic [2:0] src, input logic [31:0] alu, input logic [25:0] jt,
                       input bit hc);
    rst = r;
    bus.write_enable = we; bus.pc_write_cond = cond; bus.branch_ne = bne;
    bus.zero_flag = zf; bus.pc_source = src; bus.alu_result = alu;
    bus.jump_target = jt; bus.halt_clear = hc;
    model_step(r, we, cond, bne, zf, int'(src), longint'(alu), longint'(jt), hc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 3'd0, 0, 0, 0);
    checks += 4;
    if (bus.pc !== 32'h0100_0000) begin failures++; $display("FAIL reset_pc got=%h exp=01000000", bus.pc); end
    if (bus.halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", bus.halt); end
    if (bus.halt_cause !== 3'd0) begin failures++; $display("FAIL reset_cause got=%0d exp=0", bus.halt_cause); end
    if (bus.ras_count !== 3'd0) begin failures++; $display("FAIL reset_ras got=%0d exp=0", bus.ras_count); end
    cycle(0, 1, 0, 0, 0, 3'd0, 0, 0, 0);
    checks++;
    if (bus.pc !== 32'h0100_0004) begin failures++; $display("FAIL seq_pc got=%h exp=01000004", bus.pc); end
  endtask

  task automatic test_branch;
    cycle(0, 0, 1, 0, 1, 3'd1, 32'h0100_0010, 0, 0);
    checks++;
    if (bus.pc !== 32'h0100_0010) begin failures++; $display("FAIL branch_eq got=%h exp=01000010", bus.pc); end
    cycle(0, 0, 1, 0, 0, 3'd1, 32'h0100_0020, 0, 0);
    checks++;
    if (bus.pc !== 32'h0100_0010) begin failures++; $display("FAIL branch_not_taken got=%h exp=01000010", bus.pc); end
    cycle(0, 0, 1, 1, 0, 3'd1, 32'h0100_0018, 0, 0);
    checks++;
    if (bus.pc !== 32'h0100_0018) begin failures++; $display("FAIL branch_ne got=%h exp=01000018", bus.pc); end
    cycle(0, 1, 0, 0, 0, 3'd1, 32'h0100_0010, 0, 0);
    checks++;
    if (bus.pc !== 32'h0100_0010) begin failures++; $display("FAIL we_branch got=%h exp=01000010", bus.pc); end
  endtask

  task automatic test_call_ret;
    cycle(0, 1, 0, 0, 0, 3'd3, 0, 26'h040_0040, 0);
    checks += 2;
    if (bus.pc !== 32'h0100_0100) begin failures++; $display("FAIL call_pc got=%h exp=01000100", bus.pc); end
    if (bus.ras_count !== 3'd1) begin failures++; $display("FAIL call_ras got=%0d exp=1", bus.ras_count); end
    cycle(0, 1, 0, 0, 0, 3'd4, 0, 0, 0);
    checks += 2;
    if (bus.pc !== 32'h0100_0014) begin failures++; $display("FAIL ret_pc got=%h exp=01000014", bus.pc); end
    if (bus.ras_count !== 3'd0) begin failures++; $display("FAIL ret_ras got=%0d exp=0", bus.ras_count); end
  endtask

  task automatic test_faults;
    cycle(0, 1, 0, 0, 0, 3'd1, 32'h0200_0000, 0, 0);
    checks += 3;
    if (bus.halt !== 1'b1) begin failures++; $display("FAIL range_halt got=%b exp=1", bus.halt); end
    if (bus.halt_cause !== 3'd2) begin failures++; $display("FAIL range_cause got=%0d exp=2", bus.halt_cause); end
    if (bus.pc !== 32'h0100_0014) begin failures++; $display("FAIL range_pc_hold got=%h exp=01000014", bus.pc); end
    cycle(0, 1, 0, 0, 0, 3'd0, 0, 0, 0);
    checks += 2;
    if (bus.pc !== 32'h0100_0014) begin failures++; $display("FAIL halted_pc got=%h exp=01000014", bus.pc); end
    if (bus.halt_cause !== 3'd2) begin failures++; $display("FAIL halted_cause got=%0d exp=2", bus.halt_cause); end
    cycle(0, 0, 0, 0, 0, 3'd0, 0, 0, 1);
    checks += 2;
    if (bus.halt !== 1'b0) begin failures++; $display("FAIL clear_halt got=%b exp=0", bus.halt); end
    if (bus.halt_cause !== 3'd0) begin failures++; $display("FAIL clear_cause got=%0d exp=0", bus.halt_cause); end
    cycle(0, 1, 0, 0, 0, 3'd0, 0, 0, 1);
    checks++;
    if (bus.pc !== 32'h0100_0014) begin failures++; $display("FAIL take_with_clear got=%h exp=01000014", bus.pc); end
    cycle(0, 1, 0, 0, 0, 3'd1, 32'h0100_0003, 0, 0);
    checks++;
    if (bus.halt_cause !== 3'd1) begin failures++; $display("FAIL misalign_cause got=%0d exp=1", bus.halt_cause); end
    cycle(0, 0, 0, 0, 0, 3'd0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 3'd1, 32'h01FF_FFFC, 0, 0);
    checks++;
    if (bus.pc !== 32'h01FF_FFFC) begin failures++; $display("FAIL top_legal got=%h exp=01fffffc", bus.pc); end
    cycle(0, 1, 0, 0, 0, 3'd0, 0, 0, 0);
    checks += 2;
    if (bus.halt_cause !== 3'd2) begin failures++; $display("FAIL seq_past_top got=%0d exp=2", bus.halt_cause); end
    if (bus.pc !== 32'h01FF_FFFC) begin failures++; $display("FAIL seq_past_top_pc got=%h exp=01fffffc", bus.pc); end
  endtask

  task automatic test_ras_overflow;
    cycle(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 0, 0, 3'd3, 0, 26'(32'h40_0000 + 16 * i), 0);
    checks += 3;
    if (bus.halt_cause !== 3'd3) begin failures++; $display("FAIL overflow_cause got=%0d exp=3", bus.halt_cause); end
    if (bus.ras_count !== 3'd4) begin failures++; $display("FAIL overflow_ras got=%0d exp=4", bus.ras_count); end
    if (bus.pc !== 32'h0100_0100) begin failures++; $display("FAIL overflow_pc got=%h exp=01000100", bus.pc); end
    cycle(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 3'd4, 0, 0, 0);
    checks += 2;
    if (bus.halt_cause !== 3'd4) begin failures++; $display("FAIL underflow_cause got=%0d exp=4", bus.halt_cause); end
    if (bus.pc !== 32'h0100_0000) begin failures++; $display("FAIL underflow_pc got=%h exp=01000000", bus.pc); end
  endtask

  task automatic test_reset_halted;
    cycle(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 3'd3, 0, 26'h040_0100, 0);
    cycle(0, 1, 0, 0, 0, 3'd3, 0, 26'h040_0200, 0);
    cycle(0, 1, 0, 0, 0, 3'd1, 32'h0000_0000, 0, 0);
    checks += 2;
    if (bus.ras_count !== 3'd2) begin failures++; $display("FAIL halted_ras got=%0d exp=2", bus.ras_count); end
    if (bus.halt !== 1'b1) begin failures++; $display("FAIL low_range_halt got=%b exp=1", bus.halt); end
    cycle(1, 1, 0, 0, 0, 3'd3, 0, 26'h040_0300, 0);
    checks += 4;
    if (bus.pc !== 32'h0100_0000) begin failures++; $display("FAIL rst_halted_pc got=%h exp=01000000", bus.pc); end
    if (bus.halt !== 1'b0) begin failures++; $display("FAIL rst_halted_halt got=%b exp=0", bus.halt); end
    if (bus.halt_cause !== 3'd0) begin failures++; $display("FAIL rst_halted_cause got=%0d exp=0", bus.halt_cause); end
    if (bus.ras_count !== 3'd0) begin failures++; $display("FAIL rst_halted_ras got=%0d exp=0", bus.ras_count); end
    cycle(0, 1, 0, 0, 0, 3'd6, 0, 0, 0);
    checks++;
    if (bus.halt_cause !== 3'd5) begin failures++; $display("FAIL illegal_cause got=%0d exp=5", bus.halt_cause); end
  endtask

  task automatic test_random;
    logic [2:0]  src;
    logic [31:0] alu;
    logic [25:0] jt;
    int sel;
    cycle(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    src = 3'd0;
        2, 3:    src = 3'd1;
        4:       src = 3'd2;
        5, 6:    src = 3'd3;
        7, 8:    src = 3'd4;
        default: src = 3'(5 + $urandom_range(0, 2));
      endcase
      sel = int'($urandom_range(0, 9));
      if (sel < 7) alu = RPC + 32'($urandom_range(0, 32'h3F_FFFF)) * 4;
      else if (sel == 7) alu = RPC + 32'($urandom_range(0, 32'hFF_FFFF));
      else alu = $urandom;
      jt = ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'($urandom_range(32'h40_0000, 32'h7F_FFFF));
      cycle($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            src, alu, jt, $urandom_range(0, 4) == 0);
      checks += 4;
      if (bus.pc !== m_pc[31:0]) begin failures++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, bus.pc, m_pc[31:0]); end
      if (bus.halt !== m_halt) begin failures++; $display("FAIL rand_halt n=%0d got=%b exp=%b", n, bus.halt, m_halt); end
      if (bus.halt_cause !== 3'(m_cause)) begin failures++; $display("FAIL rand_cause n=%0d got=%0d exp=%0d", n, bus.halt_cause, m_cause); end
      if (bus.ras_count !== 3'(ras.size())) begin failures++; $display("FAIL rand_ras n=%0d got=%0d exp=%0d", n, bus.ras_count, ras.size()); end
    end
  endtask

  initial begin
    test_reset;
    test_branch;
    test_call_ret;
    test_faults;
    test_ras_overflow;
    test_reset_halted;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
